// File: rtl/enigma_pkg.sv
// Shared definitions for the Enigma datapath (input stage, rotors, reflector).
// Contents: alphabet/width constants, ASCII bases, input-stage FSM state type,
// FIFO entry layout, and plugboard helpers (identity map, partner lookup).
package enigma_pkg;

    localparam int unsigned ALPHA    = 26;
    localparam int unsigned IDX_W    = 8;
    localparam int unsigned MAP_W    = 208;
    localparam logic [7:0]  ASCII_A  = 8'h41;
    localparam logic [7:0]  ASCII_LA = 8'h61;

    typedef enum logic [0:0] {
        StIdle,
        StWait
    } fsm_state_e;

    typedef struct packed {
        logic       lower;
        logic [4:0] idx;
    } fifo_entry_t;

    localparam int unsigned ENTRY_W = $bits(fifo_entry_t);

    // Plugboard map with every letter paired to itself.
    function automatic logic [MAP_W-1:0] identity_map();
        logic [MAP_W-1:0] m;
        m = '0;
        for (int i = 0; i < int'(ALPHA); i++) begin
            m[8*i +: 8] = 8'(i);
        end
        return m;
    endfunction

    localparam logic [MAP_W-1:0] IDENTITY_MAP = identity_map();

    // Partner of letter idx; an out-of-alphabet partner falls back to the letter itself.
    function automatic logic [4:0] plug_lookup(logic [MAP_W-1:0] pmap, logic [IDX_W-1:0] idx);
        logic [7:0] p;
        p = idx;
        for (int i = 0; i < int'(ALPHA); i++) begin
            if (idx == IDX_W'(i)) begin
                p = pmap[8*i +: 8];
            end
        end
        if (p > 8'(ALPHA - 1)) begin
            p = idx;
        end
        return p[4:0];
    endfunction

endpackage

// File: rtl/enigma_input_stage_if.sv
// Byte-in / launch-out handshake bundle for enigma_input_stage.
//   valid, din, in_ready           : ASCII byte stream into the stage
//   out_valid, out_idx, out_lower  : one-cycle launch towards rotor 1
//   chain_done                     : completion pulse back from the last rotor
// master = producer of bytes / rotor side; slave = the input stage.
interface enigma_input_stage_if;
    import enigma_pkg::*;

    logic             valid;
    logic [7:0]       din;
    logic             in_ready;
    logic             out_valid;
    logic [IDX_W-1:0] out_idx;
    logic             out_lower;
    logic             chain_done;

    modport master (
        output valid, din, chain_done,
        input  in_ready, out_valid, out_idx, out_lower
    );

    modport slave (
        input  valid, din, chain_done,
        output in_ready, out_valid, out_idx, out_lower
    );

endinterface

// File: rtl/enigma_sync_fifo.sv
// Single-clock FIFO with synchronous flush.
//   clk, reset_n : clock, async active-low reset
//   flush        : empty the FIFO (wins over push/pop)
//   push, wdata  : write when not full
//   pop, rdata   : rdata is the head; pop advances when not empty
//   full, empty  : derived from pointers carrying an extra wrap bit
module enigma_sync_fifo #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic             do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/enigma_input_stage.sv
// Enigma input stage: decodes ASCII letters to 0..25 plus a case flag, applies the
// plugboard, queues entries and launches one character at a time into rotor 1,
// waiting for chain_done (or a timeout) before the next launch.
//   clk, reset_n  : clock, async active-low reset
//   set           : load plug_idx_in, flush queue, clear err/drop_cnt, FSM to idle
//   plug_idx_in   : 26 x 8-bit partner map, byte i = partner of letter i
//   en            : launch enable (bytes are still accepted when low)
//   bus           : byte input and launch handshake (slave side)
//   busy          : waiting for the in-flight character
//   err           : sticky timeout flag
//   drop_cnt      : saturating count of consumed non-letter bytes
module enigma_input_stage
    import enigma_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 set,
    input  logic [MAP_W-1:0]     plug_idx_in,
    input  logic                 en,
    enigma_input_stage_if.slave  bus,
    output logic                 busy,
    output logic                 err,
    output logic [15:0]          drop_cnt
);

    localparam int unsigned TMO_W   = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_ONE = TMO_W'(1);

    logic [MAP_W-1:0] plug_q;
    fsm_state_e       state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             out_valid_q, out_valid_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d;
    logic             out_lower_q, out_lower_d;
    logic             err_q, err_d;
    logic [15:0]      drop_q, drop_d;

    logic             is_upper, is_lower, is_letter;
    logic [IDX_W-1:0] letter_idx;
    logic             in_ready, accept, push, pop;
    logic             fifo_full, fifo_empty;
    fifo_entry_t      wr_entry, rd_entry;

    // Decode and plug lookup happen at write time so the queue holds plugged letters.
    always_comb begin
        is_upper   = (bus.din >= ASCII_A) && (bus.din <= ASCII_A + 8'd25);
        is_lower   = (bus.din >= ASCII_LA) && (bus.din <= ASCII_LA + 8'd25);
        is_letter  = is_upper || is_lower;
        letter_idx = is_lower ? (bus.din - ASCII_LA) : (bus.din - ASCII_A);
        wr_entry.lower = is_lower;
        wr_entry.idx   = plug_lookup(plug_q, letter_idx);
    end

    assign in_ready = !fifo_full && !set;
    assign accept   = bus.valid && in_ready;
    assign push     = accept && is_letter;

    enigma_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (set),
        .push    (push),
        .wdata   (wr_entry),
        .pop     (pop),
        .rdata   (rd_entry),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        tmo_d       = tmo_q;
        out_valid_d = 1'b0;
        out_idx_d   = out_idx_q;
        out_lower_d = out_lower_q;
        err_d       = err_q;
        pop         = 1'b0;
        if (set) begin
            state_d = StIdle;
            tmo_d   = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (en && !fifo_empty) begin
                        pop         = 1'b1;
                        out_valid_d = 1'b1;
                        out_idx_d   = IDX_W'(rd_entry.idx);
                        out_lower_d = rd_entry.lower;
                        tmo_d       = '0;
                        state_d     = StWait;
                    end
                end
                StWait: begin
                    // chain_done in the launch cycle cannot belong to this character.
                    if (bus.chain_done && !out_valid_q) begin
                        state_d = StIdle;
                    end else if (tmo_q == TMO_MAX) begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end else begin
                        tmo_d = tmo_q + TMO_ONE;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        drop_d = drop_q;
        if (set) begin
            drop_d = '0;
        end else if (accept && !is_letter && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            plug_q      <= IDENTITY_MAP;
            state_q     <= StIdle;
            tmo_q       <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_lower_q <= 1'b0;
            err_q       <= 1'b0;
            drop_q      <= '0;
        end else begin
            if (set) plug_q <= plug_idx_in;
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_lower_q <= out_lower_d;
            err_q       <= err_d;
            drop_q      <= drop_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_lower = out_lower_q;
    assign busy          = (state_q == StWait);
    assign err           = err_q;
    assign drop_cnt      = drop_q;

endmodule

// File: tb/tb_enigma_input_stage.sv
// Self-checking bench for enigma_input_stage: a queue-based behavioural model is
// compared against the DUT on every falling edge; directed scenarios add literal checks.
module tb_enigma_input_stage;
    import enigma_pkg::*;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 20;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             set = 1'b0;
    logic             en = 1'b0;
    logic [MAP_W-1:0] plug_idx_in = '0;
    logic             busy, err;
    logic [15:0]      drop_cnt;

    enigma_input_stage_if bus ();

    enigma_input_stage #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .set         (set),
        .plug_idx_in (plug_idx_in),
        .en          (en),
        .bus         (bus.slave),
        .busy        (busy),
        .err         (err),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    typedef struct {
        int idx;
        bit low;
    } ent_t;

    ent_t m_q[$];
    int   m_plug[ALPHA];
    bit   m_busy, m_ov, m_olow, m_err;
    int   m_oidx, m_drop, m_age;

    function automatic void model_reset();
        m_q.delete();
        for (int i = 0; i < int'(ALPHA); i++) m_plug[i] = i;
        m_busy = 0; m_ov = 0; m_olow = 0; m_err = 0;
        m_oidx = 0; m_drop = 0; m_age = 0;
    endfunction

    function automatic void model_step();
        int   c, idx, p;
        bit   low, letter, ready, accept;
        ent_t e;
        if (set) begin
            for (int i = 0; i < int'(ALPHA); i++) m_plug[i] = int'(plug_idx_in[8*i +: 8]);
            m_q.delete();
            m_busy = 0; m_ov = 0; m_err = 0; m_drop = 0; m_age = 0;
            return;
        end
        ready  = m_q.size() < int'(DEPTH);
        accept = bus.valid && ready;
        // launch decision sees the queue as it stood before this edge
        m_ov = 0;
        if (!m_busy) begin
            if (en && m_q.size() > 0) begin
                e = m_q.pop_front();
                m_ov = 1; m_oidx = e.idx; m_olow = e.low;
                m_busy = 1; m_age = 0;
            end
        end else begin
            if (bus.chain_done && m_age > 0) m_busy = 0;
            else if (m_age == int'(TIMEOUT)) begin m_err = 1; m_busy = 0; end
            else m_age++;
        end
        if (accept) begin
            c = int'(bus.din);
            letter = 1; low = 0; idx = 0;
            if (c >= 65 && c <= 90) idx = c - 65;
            else if (c >= 97 && c <= 122) begin idx = c - 97; low = 1; end
            else letter = 0;
            if (letter) begin
                p = m_plug[idx];
                if (p > 25) p = idx;
                e.idx = p; e.low = low;
                m_q.push_back(e);
            end else if (m_drop < 65535) m_drop++;
        end
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) model_reset();
            else model_step();
        end
    end

    // ---------------- per-cycle comparison ----------------
    initial begin
        forever begin
            @(negedge clk);
            chk("in_ready",  int'(bus.in_ready),  (m_q.size() < int'(DEPTH) && !set) ? 1 : 0);
            chk("out_valid", int'(bus.out_valid), int'(m_ov));
            chk("out_idx",   int'(bus.out_idx),   m_oidx);
            chk("out_lower", int'(bus.out_lower), int'(m_olow));
            chk("busy",      int'(busy),          int'(m_busy));
            chk("err",       int'(err),           int'(m_err));
            chk("drop_cnt",  int'(drop_cnt),      m_drop);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_set();
        set = 1'b1;
        tick();
        set = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        bus.valid = 1'b1;
        bus.din   = b;
        tick();
        bus.valid = 1'b0;
    endtask

    task automatic pulse_done();
        bus.chain_done = 1'b1;
        tick();
        bus.chain_done = 1'b0;
    endtask

    task automatic wait_launch(input string name, input int exp_idx, input int exp_low);
        int n;
        n = 0;
        while (!bus.out_valid && n < int'(3 * TIMEOUT)) begin
            tick();
            n++;
        end
        chk({name, "_seen"},  int'(bus.out_valid), 1);
        chk({name, "_idx"},   int'(bus.out_idx),   exp_idx);
        chk({name, "_lower"}, int'(bus.out_lower), exp_low);
    endtask

    function automatic logic [MAP_W-1:0] random_map();
        logic [MAP_W-1:0] m;
        for (int i = 0; i < int'(ALPHA); i++) begin
            if ($urandom_range(0, 3) == 0) m[8*i +: 8] = 8'($urandom_range(26, 255));
            else m[8*i +: 8] = 8'($urandom_range(0, 25));
        end
        return m;
    endfunction

    // ---------------- directed + random scenarios ----------------
    initial begin
        logic [MAP_W-1:0] az_map;
        int done_pct;

        bus.valid = 1'b0;
        bus.din = 8'h00;
        bus.chain_done = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();

        // 1: reset state, then a plain letter with identity plugboard
        chk("t1_in_ready", int'(bus.in_ready), 1);
        chk("t1_out_valid", int'(bus.out_valid), 0);
        chk("t1_busy", int'(busy), 0);
        chk("t1_err", int'(err), 0);
        chk("t1_drop", int'(drop_cnt), 0);
        en = 1'b1;
        send(8'h43);
        tick();
        chk("t1_launch", int'(bus.out_valid), 1);
        chk("t1_idx", int'(bus.out_idx), 2);
        tick();
        pulse_done();
        chk("t1_idle", int'(busy), 0);

        // 2: A<->Z plugboard, launch latency and chain_done return
        az_map = IDENTITY_MAP;
        az_map[7:0] = 8'd25;
        az_map[207:200] = 8'd0;
        plug_idx_in = az_map;
        do_set();
        send(8'h41);
        tick();
        chk("t2_launch", int'(bus.out_valid), 1);
        chk("t2_idx", int'(bus.out_idx), 25);
        chk("t2_lower", int'(bus.out_lower), 0);
        repeat (5) tick();
        chk("t2_busy_n7", int'(busy), 1);
        bus.chain_done = 1'b1;
        tick();
        bus.chain_done = 1'b0;
        chk("t2_idle_n8", int'(busy), 0);
        chk("t2_idx_hold", int'(bus.out_idx), 25);

        // 3: 'b','1','c' back to back
        bus.valid = 1'b1;
        bus.din = 8'h62;
        tick();
        bus.din = 8'h31;
        tick();
        chk("t3_launch1", int'(bus.out_valid), 1);
        chk("t3_idx1", int'(bus.out_idx), 1);
        chk("t3_lower1", int'(bus.out_lower), 1);
        bus.din = 8'h63;
        tick();
        bus.valid = 1'b0;
        chk("t3_drop", int'(drop_cnt), 1);
        repeat (3) tick();
        chk("t3_no_launch", int'(bus.out_valid), 0);
        chk("t3_still_busy", int'(busy), 1);
        pulse_done();
        tick();
        chk("t3_launch2", int'(bus.out_valid), 1);
        chk("t3_idx2", int'(bus.out_idx), 2);
        chk("t3_lower2", int'(bus.out_lower), 1);
        tick();
        pulse_done();

        // 4: fill with en low, fifth byte held off, then drain in order
        en = 1'b0;
        for (int i = 0; i < 4; i++) send(8'(68 + i));
        chk("t4_full", int'(bus.in_ready), 0);
        bus.valid = 1'b1;
        bus.din = 8'h48;
        repeat (2) tick();
        chk("t4_held", int'(bus.in_ready), 0);
        chk("t4_no_launch", int'(busy), 0);
        en = 1'b1;
        tick();
        chk("t4_d_launch", int'(bus.out_valid), 1);
        chk("t4_d_idx", int'(bus.out_idx), 3);
        chk("t4_room", int'(bus.in_ready), 1);
        tick();
        bus.valid = 1'b0;
        pulse_done();
        for (int i = 4; i < 8; i++) begin
            wait_launch("t4_drain", i, 0);
            tick();
            pulse_done();
        end

        // 5: timeout
        do_set();
        bus.valid = 1'b1;
        bus.din = 8'h4B;
        tick();
        bus.din = 8'h4C;
        tick();
        bus.valid = 1'b0;
        chk("t5_launch", int'(bus.out_idx), 10);
        repeat (TIMEOUT) tick();
        chk("t5_err_pre", int'(err), 0);
        chk("t5_busy_pre", int'(busy), 1);
        tick();
        chk("t5_err", int'(err), 1);
        chk("t5_idle", int'(busy), 0);
        tick();
        chk("t5_next_launch", int'(bus.out_valid), 1);
        chk("t5_next_idx", int'(bus.out_idx), 11);
        do_set();
        chk("t5_err_clr", int'(err), 0);
        chk("t5_busy_clr", int'(busy), 0);

        // 6: async reset mid-wait with 3 queued
        bus.valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.din = 8'(80 + i);
            tick();
        end
        bus.valid = 1'b0;
        chk("t6_busy", int'(busy), 1);
        bus.din = 8'h21;
        send(8'h21);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_valid", int'(bus.out_valid), 0);
        chk("t6_rst_idx", int'(bus.out_idx), 0);
        chk("t6_rst_lower", int'(bus.out_lower), 0);
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_drop", int'(drop_cnt), 0);
        chk("t6_rst_ready", int'(bus.in_ready), 1);
        tick();
        reset_n = 1'b1;
        repeat (2) tick();
        chk("t6_empty", int'(busy), 0);
        send(8'h41);
        tick();
        chk("t6_ident_launch", int'(bus.out_valid), 1);
        chk("t6_ident_idx", int'(bus.out_idx), 0);
        tick();
        pulse_done();

        // drop counter saturation
        do_set();
        bus.valid = 1'b1;
        bus.din = 8'h20;
        repeat (65535) tick();
        chk("sat_reach", int'(drop_cnt), 65535);
        repeat (3) tick();
        chk("sat_hold", int'(drop_cnt), 65535);
        bus.valid = 1'b0;
        do_set();
        chk("sat_clear", int'(drop_cnt), 0);

        // random traffic
        plug_idx_in = random_map();
        do_set();
        done_pct = 35;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cyc % 500 == 0) done_pct = ((cyc / 500) % 2 == 1) ? 2 : 35;
            set = ($urandom_range(0, 199) == 0);
            if (set) plug_idx_in = random_map();
            en = ($urandom_range(0, 99) < 80);
            bus.valid = ($urandom_range(0, 99) < 55);
            if ($urandom_range(0, 3) == 0) bus.din = 8'($urandom_range(0, 255));
            else bus.din = 8'(($urandom_range(0, 1) == 1 ? 97 : 65) + $urandom_range(0, 25));
            bus.chain_done = ($urandom_range(0, 99) < done_pct);
            if ($urandom_range(0, 799) == 0) begin
                #2;
                reset_n = 1'b0;
                tick();
                reset_n = 1'b1;
            end
            tick();
        end
        set = 1'b0;
        bus.valid = 1'b0;
        bus.chain_done = 1'b0;
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
